// File: rtl/turn_pkg.sv
// turn_pkg: command codes and sequencer state encoding shared by the turn sequencer
package turn_pkg;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_BACK  = 2'b11;

    typedef enum logic [1:0] {IDLE, TURN, GAP} state_t;

endpackage

// File: rtl/turn_cmd_fifo.sv
// turn_cmd_fifo: small 2-bit command FIFO with flush; pointers wrap for any depth
module turn_cmd_fifo #(
    parameter int QUEUE_DEPTH = 4,
    parameter int QW = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [1:0]    din,
    output logic [1:0]    dout,
    output logic [QW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);

    logic [1:0]    mem [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = count == QW'(QUEUE_DEPTH);
    assign empty = count == '0;

    // pointers and occupancy; flush returns to the empty state
    always_ff @(negedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? (wr_ptr == LAST ? '0 : wr_ptr + PW'(1)) : wr_ptr;
            rd_ptr <= pop ? (rd_ptr == LAST ? '0 : rd_ptr + PW'(1)) : rd_ptr;
            count  <= count + QW'(push) - QW'(pop);
        end

    // storage needs no reset; occupancy alone defines what is valid
    always_ff @(negedge clk)
        if (push && !flush) mem[wr_ptr] <= din;

endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: queues turn commands and plays them out with per-type durations and a straight gap
module turn_sequencer
    import turn_pkg::*;
#(
    parameter int TURN_TIME   = 450,
    parameter int BACK_MULT   = 2,
    parameter int GAP_TIME    = 50,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             cmd_valid,
    input  logic [1:0]                       cmd_code,
    input  logic                             abort,
    output logic                             cmd_ready,
    output logic                             turn_left,
    output logic                             turn_right,
    output logic                             is_turning,
    output logic                             busy,
    output logic                             turn_done,
    output logic                             overflow,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);

    localparam logic [CNT_W-1:0] TURN_LIM = CNT_W'(TURN_TIME - 1);
    localparam logic [CNT_W-1:0] BACK_LIM = CNT_W'(TURN_TIME * BACK_MULT - 1);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_TIME > 0 ? GAP_TIME - 1 : 0);

    state_t           state, state_nx;
    logic [1:0]       cur_cmd, cur_nx, head;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             full, empty, kill, cmd_ok, push, pop, at_lim;

    assign kill      = abort || !enable;
    assign cmd_ok    = cmd_valid && cmd_code != CMD_NONE;
    assign cmd_ready = enable && !full && !rst;
    assign push      = cmd_ok && cmd_ready && !kill;
    assign pop       = state == IDLE && !empty && !kill;
    assign at_lim    = cnt == (cur_cmd == CMD_BACK ? BACK_LIM : TURN_LIM);

    turn_cmd_fifo #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (kill),
        .din   (cmd_code),
        .dout  (head),
        .count (queue_count),
        .full  (full),
        .empty (empty)
    );

    // state, current command and duration counter
    always_ff @(negedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            cur_cmd <= CMD_NONE;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            cur_cmd <= cur_nx;
            cnt     <= cnt_nx;
        end

    // next state: abort or disable wins over every transition
    always_comb begin
        state_nx = state;
        cur_nx   = cur_cmd;
        cnt_nx   = cnt + CNT_W'(1);
        if (kill) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else
            case (state)
                IDLE: begin
                    cnt_nx = '0;
                    if (pop) begin
                        state_nx = TURN;
                        cur_nx   = head;
                    end
                end
                TURN: if (at_lim) begin
                    state_nx = GAP_TIME == 0 ? IDLE : GAP;
                    cnt_nx   = '0;
                end
                GAP: if (cnt == GAP_LIM) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
                default: state_nx = IDLE;
            endcase
    end

    // sticky overflow on a dropped command while active
    always_ff @(negedge clk or posedge rst)
        if (rst) overflow <= 1'b0;
        else     overflow <= overflow | (cmd_ok && enable && full);

    // steering decode; back turns steer right
    always_comb begin
        is_turning = state == TURN;
        turn_left  = is_turning && cur_cmd == CMD_LEFT;
        turn_right = is_turning && cur_cmd != CMD_LEFT;
        busy       = state != IDLE;
        turn_done  = is_turning && at_lim && !kill;
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed and random stimulus against a queue-based turn model
module tb_turn_sequencer;

    localparam int TT = 4;
    localparam int BM = 2;
    localparam int GT = 2;
    localparam int QD = 2;
    localparam int QW = $clog2(QD + 1);

    logic          clk = 1'b1;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_code = 2'b00;
    logic          abort = 1'b0;
    logic          cmd_ready, turn_left, turn_right, is_turning, busy, turn_done, overflow;
    logic [QW-1:0] queue_count;

    int total = 0;
    int bad = 0;

    int q[$];
    int mode = 0;
    int rem = 0;
    int cur = 0;
    bit ovf = 0;

    turn_sequencer #(
        .TURN_TIME(TT), .BACK_MULT(BM), .GAP_TIME(GT), .QUEUE_DEPTH(QD), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .abort(abort), .cmd_ready(cmd_ready), .turn_left(turn_left), .turn_right(turn_right),
        .is_turning(is_turning), .busy(busy), .turn_done(turn_done), .overflow(overflow),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit kill = abort || !enable;
        chk("cmd_ready", 8'(cmd_ready), 8'(!rst && enable && q.size() < QD));
        chk("turn_left", 8'(turn_left), 8'(mode == 1 && cur == 1));
        chk("turn_right", 8'(turn_right), 8'(mode == 1 && cur != 1));
        chk("is_turning", 8'(is_turning), 8'(mode == 1));
        chk("busy", 8'(busy), 8'(mode != 0));
        chk("turn_done", 8'(turn_done), 8'(mode == 1 && rem == 1 && !kill));
        chk("overflow", 8'(overflow), 8'(ovf));
        chk("queue_count", 8'(queue_count), 8'(q.size()));
    endtask

    task automatic model_edge();
        bit kill = abort || !enable;
        bit valid = cmd_valid && cmd_code != 2'b00;
        int sz = q.size();
        if (valid && enable && sz == QD) ovf = 1;
        if (kill) begin
            q.delete();
            mode = 0;
            rem = 0;
        end else begin
            case (mode)
                0: if (sz > 0) begin
                    cur = q.pop_front();
                    mode = 1;
                    rem = (cur == 3) ? TT * BM : TT;
                end
                1: if (rem == 1) begin
                    mode = GT > 0 ? 2 : 0;
                    rem = GT;
                end else rem--;
                default: if (rem == 1) mode = 0; else rem--;
            endcase
            if (valid && sz < QD) q.push_back(int'(cmd_code));
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = 0;
        rem = 0;
        cur = 0;
        ovf = 0;
    endtask

    task automatic step(input bit v, input logic [1:0] c, input bit ab, input bit en);
        @(posedge clk);
        cmd_valid = v;
        cmd_code = c;
        abort = ab;
        enable = en;
        #1;
        check_all();
        @(negedge clk);
        model_edge();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    initial begin
        #1;
        check_all();
        repeat (2) @(posedge clk);
        rst = 1'b0;
        idle(2);
        // single left turn
        step(1'b1, 2'b01, 1'b0, 1'b1);
        idle(9);
        // back turn
        step(1'b1, 2'b11, 1'b0, 1'b1);
        idle(13);
        // enable drop during the gap with a command held
        step(1'b1, 2'b01, 1'b0, 1'b1);
        idle(6);
        repeat (4) step(1'b1, 2'b10, 1'b0, 1'b0);
        idle(2);
        // abort in the second turn cycle with one entry queued
        step(1'b1, 2'b01, 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        idle(3);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        // queue fill and overflow while a back turn runs
        step(1'b1, 2'b11, 1'b0, 1'b1);
        idle(1);
        step(1'b1, 2'b01, 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 1'b1);
        step(1'b1, 2'b11, 1'b0, 1'b1);
        idle(30);
        // random traffic
        repeat (600)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 19) != 0);
        idle(20);
        // asynchronous reset in the middle of a turn
        step(1'b1, 2'b01, 1'b0, 1'b1);
        idle(3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        rst = 1'b0;
        idle(2);
        step(1'b1, 2'b10, 1'b0, 1'b1);
        idle(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Parametrised successor to the single-shot auto-turn controller in the car simulation Main path.
- Accepts turn commands (left / right / back) into a small queue and executes them one at a time, with a configurable duration per turn type and a straight-driving gap between turns.
- Drives the steering flags consumed by the motion/display logic.
- Adds abort, a completion pulse, overflow reporting and a queue level output.

Parameters:
- TURN_TIME, 450, cycles for a left/right turn (0.9 s at 500 Hz); must be >= 1.
- BACK_MULT, 2, back-turn duration = TURN_TIME*BACK_MULT cycles; must be >= 1.
- GAP_TIME, 50, straight cycles inserted after each turn; 0 = no gap state.
- QUEUE_DEPTH, 4, command queue entries; must be >= 1.
- CNT_W, 16, duration counter width; TURN_TIME*BACK_MULT and GAP_TIME must each be < 2^CNT_W.

Ports:
- clk  in  1  system clock (500 Hz)
- rst  in  1  asynchronous active-high reset
- enable  in  1  block active; low flushes everything
- cmd_valid  in  1  command offered this cycle
- cmd_code  in  2  01 = left, 10 = right, 11 = back, 00 = ignored
- abort  in  1  one-cycle request: stop current turn, flush queue
- cmd_ready  out  1  queue can accept (count < QUEUE_DEPTH and enable)
- turn_left  out  1  steer left
- turn_right  out  1  steer right
- is_turning  out  1  a turn is in progress
- busy  out  1  in TURN or GAP state
- turn_done  out  1  one-cycle pulse when a turn completes normally
- overflow  out  1  sticky; set when a valid command arrives while the queue is full
- queue_count  out  $clog2(QUEUE_DEPTH+1)  entries waiting

Behaviour:
- Clocking and reset:
  - All registers update on the falling edge of clk.
  - rst asynchronously forces state IDLE, queue empty, counter 0, overflow 0, and all outputs 0.
- Queue push:
  - Push when cmd_valid && cmd_code != 00 && cmd_ready.
  - cmd_ready is derived from the registered count, so a pop in the same cycle does not free a slot.
  - No bypass: a pushed command is executed at the earliest one cycle later.
- Overflow:
  - cmd_valid && cmd_code != 00 && enable && count == QUEUE_DEPTH → command dropped, overflow set.
  - overflow is cleared only by rst.
- Simultaneous push and pop leaves count unchanged; FIFO order is preserved.
- States: IDLE, TURN, GAP.
  - IDLE: if count > 0, pop the head into cur_cmd, counter := 0, go to TURN.
  - TURN: counter increments each cycle. Limit is TURN_TIME-1 (left/right) or TURN_TIME*BACK_MULT-1 (back). At the limit:
    - turn_done pulses in that same cycle;
    - go to GAP with counter := 0, or directly to IDLE if GAP_TIME == 0.
  - GAP: at counter == GAP_TIME-1, go to IDLE. Back-to-back queued turns are therefore separated by GAP_TIME + 1 cycles of IDLE/GAP.
- Outputs (decoded combinationally from registered state/cur_cmd):
  - IDLE and GAP: turn_left, turn_right and is_turning all 0.
  - TURN left: turn_left=1, turn_right=0, is_turning=1.
  - TURN right or back: turn_left=0, turn_right=1, is_turning=1.
  - busy = (state != IDLE).
- Abort: abort, or enable low, at a clock edge sends state to IDLE, empties the queue and clears the counter.
  - turn_done does not pulse.
  - Any push in that same cycle is discarded.
  - abort while IDLE with an empty queue has no effect.
- enable low holds the block in IDLE with cmd_ready=0; the queue stays empty. overflow is not set while enable is low.
- Reset mid-turn: the outputs drop in the same instant (asynchronous), with no turn_done pulse.

Decomposition:
- Package turn_pkg:
  - command code constants: CMD_NONE, CMD_LEFT, CMD_RIGHT, CMD_BACK;
  - state encoding: IDLE, TURN, GAP.
- Sub-module turn_cmd_fifo: 2-bit-wide synchronous FIFO.
  - Parameter: QUEUE_DEPTH.
  - Signals: push, pop, flush, count, full, empty.
  - Uses pointer wrap for non-power-of-2 depths.
- Sequencer FSM, counter and output decode stay in turn_sequencer.

Test Plan (TURN_TIME=4, BACK_MULT=2, GAP_TIME=2, QUEUE_DEPTH=2):
- Single left:
  - Stimulus: push 01 once.
  - Response: turn_left=1 and is_turning=1 for exactly 4 cycles; turn_done pulses on the 4th; busy stays high 2 more cycles, then IDLE.
- Back turn:
  - Stimulus: push 11.
  - Response: turn_right=1 for 8 cycles, turn_left=0 throughout, a single turn_done.
- Queue/overflow:
  - Stimulus: push 01, 10, 11 on consecutive cycles while the first is still queued.
  - Response: the third command is dropped, overflow=1, queue_count peaks at 2; left then right execute, each followed by a 2-cycle gap.
- Abort:
  - Stimulus: abort in the 2nd TURN cycle with 1 entry queued.
  - Response: next cycle IDLE, queue_count=0, no turn_done, outputs 0.
- Enable drop:
  - Stimulus: enable=0 mid-GAP with cmd_valid held.
  - Response: IDLE, cmd_ready=0, no push, overflow stays 0.
- Async reset:
  - Stimulus: assert rst between clock edges during TURN.
  - Response: turn_left, turn_right, is_turning, busy and overflow read 0 before the next edge.
